// File: rtl/system_pio_pkg.sv
// Shared constants for the input PIO: register word addresses and edge-type encodings.
package system_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Per-bit capture decision for a given edge-type setting.
    function automatic logic edge_hit(input int edge_type, input logic rise, input logic fall);
        logic hit;
        case (edge_type)
            int'(EDGE_FALL): hit = fall;
            int'(EDGE_ANY):  hit = rise | fall;
            default:         hit = rise;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/system_pio_in_edge_if.sv
// Avalon-MM slave bus of the input PIO, including its interrupt line.
interface system_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/system_pio_debounce.sv
// One input bit: synchroniser chain, optional stable-count debounce, and a rise/fall
// pulse that is high in the cycle before the debounced value changes.
module system_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // Debounced value is the last sync flop, so its next value is the flop before it.
            assign dout = sync_out;
            assign rise = sync_q[SYNC_STAGES-2] & ~sync_out;
            assign fall = ~sync_q[SYNC_STAGES-2] & sync_out;
        end else begin : g_deb
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

            logic [CW-1:0] cnt_q;
            logic          deb_q;
            logic          differ;
            logic          done;

            assign differ = sync_out ^ deb_q;
            assign done   = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else if (!differ) begin
                    cnt_q <= '0;
                end else if (done) begin
                    deb_q <= sync_out;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign dout = deb_q;
            assign rise = done & sync_out;
            assign fall = done & ~sync_out;
        end
    endgenerate

endmodule

// File: rtl/system_pio_in_edge.sv
// Avalon-MM input PIO: per-bit sync/debounce, sticky edge capture with write-to-clear,
// interrupt mask, registered read mux and a level interrupt.
module system_pio_in_edge
    import system_pio_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0,
    parameter int BIT_CLEAR       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_port,
    system_pio_in_edge_if.slave  bus
);

    logic [WIDTH-1:0] data_deb;
    logic [WIDTH-1:0] rise_p;
    logic [WIDTH-1:0] fall_p;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] mask_q;
    logic [31:0]      rd_mux;
    logic             wr_en;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            system_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .din   (in_port[i]),
                .dout  (data_deb[i]),
                .rise  (rise_p[i]),
                .fall  (fall_p[i])
            );
            assign edge_set[i] = edge_hit(EDGE_TYPE, rise_p[i], fall_p[i]);
        end
    endgenerate

    assign wr_en = bus.chipselect & ~bus.write_n;

    always_comb begin
        edge_clr = '0;
        if (wr_en && bus.address == ADDR_EDGE)
            edge_clr = (BIT_CLEAR != 0) ? bus.writedata[WIDTH-1:0] : '1;
    end

    // A fresh edge in the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) edge_q <= '0;
        else       edge_q <= (edge_q & ~edge_clr) | edge_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 mask_q <= '0;
        else if (wr_en && bus.address == ADDR_MASK) mask_q <= bus.writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = data_deb;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_q;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_mux;
    end

    assign bus.irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_system_pio_in_edge.sv
// Directed bench for the input PIO: stimulus pushes expected values into queues and a
// negedge monitor pops and compares them against what the DUTs present.
module tb_system_pio_in_edge;
    import system_pio_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] in_a, in_b;

    always #5 clk = ~clk;

    system_pio_in_edge_if bus_a ();
    system_pio_in_edge_if bus_b ();

    system_pio_in_edge #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .BIT_CLEAR(1)
    ) dut_a (
        .clk(clk), .reset(reset), .in_port(in_a), .bus(bus_a.slave)
    );

    system_pio_in_edge #(
        .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .BIT_CLEAR(1)
    ) dut_b (
        .clk(clk), .reset(reset), .in_port(in_b), .bus(bus_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { string name; logic [31:0] exp; } exp_t;
    typedef struct { string name; int kind; logic [31:0] exp; } now_t;

    exp_t q_rd_a[$];
    exp_t q_rd_b[$];
    now_t q_now[$];

    logic rd_a_seen = 1'b0;
    logic rd_b_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // A read strobe sampled on a rising edge means readdata for it is loaded on that edge.
    always @(posedge clk) begin
        rd_a_seen <= bus_a.chipselect & bus_a.write_n;
        rd_b_seen <= bus_b.chipselect & bus_b.write_n;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        now_t n;
        if (rd_a_seen) begin
            if (q_rd_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_a_unexpected: got 0x%08h expected no read", bus_a.readdata);
            end else begin
                e = q_rd_a.pop_front();
                check(e.name, bus_a.readdata, e.exp);
            end
        end
        if (rd_b_seen) begin
            if (q_rd_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_b_unexpected: got 0x%08h expected no read", bus_b.readdata);
            end else begin
                e = q_rd_b.pop_front();
                check(e.name, bus_b.readdata, e.exp);
            end
        end
        while (q_now.size() > 0) begin
            n = q_now.pop_front();
            case (n.kind)
                0:       check(n.name, {31'b0, bus_a.irq}, n.exp);
                1:       check(n.name, {31'b0, bus_b.irq}, n.exp);
                default: check(n.name, bus_a.readdata, n.exp);
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] exp, input string name);
        if (sel == 0) begin
            bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
            q_rd_a.push_back('{name, exp});
        end else begin
            bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
            q_rd_b.push_back('{name, exp});
        end
        tick(1);
        bus_a.chipselect = 1'b0;
        bus_b.chipselect = 1'b0;
    endtask

    task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
        end else begin
            bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
        end
        tick(1);
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    endtask

    // kind 0: irq of A, 1: irq of B, 2: readdata of A; checked at the next negedge
    task automatic expect_now(input int kind, input logic [31:0] exp, input string name);
        q_now.push_back('{name, kind, exp});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1;
        in_a = 4'b0000;
        in_b = 4'b0000;
        bus_a.address = ADDR_DATA; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
        bus_b.address = ADDR_DATA; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
        tick(2);
        expect_now(2, 0, "rst_readdata");
        expect_now(0, 0, "rst_irq_a");
        expect_now(1, 0, "rst_irq_b");
        tick(1);
        reset = 1'b0;

        rd(0, ADDR_DATA, 0, "rst_data");
        rd(0, ADDR_MASK, 0, "rst_mask");
        rd(0, ADDR_EDGE, 0, "rst_edge");
        rd(0, ADDR_RSVD, 0, "rst_rsvd");

        // Step latency: debounced value changes on the 6th edge, readdata one edge later.
        in_a = 4'b0101;
        tick(4);
        rd(0, ADDR_DATA, 0, "data_edge5");
        rd(0, ADDR_DATA, 0, "data_edge6");
        rd(0, ADDR_DATA, 32'h5, "data_edge7");
        rd(0, ADDR_EDGE, 32'h5, "edge_0101");
        expect_now(0, 0, "irq_masked_off");

        // Three-cycle glitch on bit 1 must not pass the 4-cycle debounce.
        wr(0, ADDR_EDGE, 32'hF);
        rd(0, ADDR_EDGE, 0, "edge_clr_all");
        in_a = 4'b0111;
        tick(3);
        in_a = 4'b0101;
        tick(8);
        rd(0, ADDR_DATA, 32'h5, "glitch_data");
        rd(0, ADDR_EDGE, 0, "glitch_edge");

        wr(0, ADDR_MASK, 32'hFFFF_FFF2);
        rd(0, ADDR_MASK, 32'h2, "mask_upper_ignored");
        wr(0, ADDR_DATA, 32'hF);
        wr(0, ADDR_RSVD, 32'hF);
        rd(0, ADDR_MASK, 32'h2, "mask_after_ro_wr");
        rd(0, ADDR_DATA, 32'h5, "data_after_ro_wr");
        rd(0, ADDR_RSVD, 0, "rsvd_after_wr");
        expect_now(0, 0, "irq_pre_edge");

        // Masked rising edge on bit 1: capture on edge 6, irq visible right after it.
        in_a = 4'b0111;
        tick(5);
        expect_now(0, 0, "irq_edge5");
        tick(1);
        expect_now(0, 1, "irq_edge6");
        rd(0, ADDR_EDGE, 32'h2, "edge_bit1");
        wr(0, ADDR_EDGE, 32'h1);
        expect_now(0, 1, "irq_after_clr_bit0");
        rd(0, ADDR_EDGE, 32'h2, "bitclear_keeps_bit1");
        wr(0, ADDR_EDGE, 32'h2);
        expect_now(0, 0, "irq_after_clr_bit1");
        rd(0, ADDR_EDGE, 0, "edge_cleared");

        // Falling edge ignored for rising-only capture; then set-vs-clear collision.
        in_a = 4'b0110;
        tick(8);
        rd(0, ADDR_EDGE, 0, "fall_ignored");
        rd(0, ADDR_DATA, 32'h6, "data_0110");
        in_a = 4'b0111;
        tick(5);
        wr(0, ADDR_EDGE, 32'h1);
        rd(0, ADDR_EDGE, 32'h1, "set_wins_over_clr");

        // Any-edge instance: both directions captured on bit 3.
        in_b = 4'b1000;
        tick(8);
        rd(1, ADDR_EDGE, 32'h8, "any_rise");
        wr(1, ADDR_EDGE, 32'h8);
        rd(1, ADDR_EDGE, 0, "any_clr");
        in_b = 4'b0000;
        tick(8);
        rd(1, ADDR_EDGE, 32'h8, "any_fall");
        rd(1, ADDR_DATA, 0, "any_data_low");
        expect_now(1, 0, "any_irq_unmasked");
        wr(1, ADDR_MASK, 32'h8);
        expect_now(1, 1, "any_irq_masked");

        // Reset in the middle of a debounce clears everything before the next clock edge.
        wr(0, ADDR_MASK, 32'h1);
        expect_now(0, 1, "irq_pre_rst");
        rd(0, ADDR_DATA, 32'h7, "data_pre_rst");
        in_a = 4'b0011;
        tick(3);
        reset = 1'b1;
        #1;
        expect_now(2, 0, "rst_async_readdata");
        expect_now(0, 0, "rst_async_irq_a");
        expect_now(1, 0, "rst_async_irq_b");
        tick(2);
        reset = 1'b0;
        tick(7);
        rd(0, ADDR_DATA, 32'h3, "post_rst_data");
        rd(0, ADDR_EDGE, 32'h3, "post_rst_edge");
        rd(0, ADDR_MASK, 0, "post_rst_mask");
        expect_now(0, 0, "post_rst_irq");

        for (int i = 0; i < 20 && (q_rd_a.size() + q_rd_b.size() + q_now.size()) > 0; i++)
            @(negedge clk);
        #1;
        if ((q_rd_a.size() + q_rd_b.size() + q_now.size()) > 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: got %0d pending checks expected 0",
                     q_rd_a.size() + q_rd_b.size() + q_now.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
